// File: rtl/winograd_tile_scheduler_if.sv
// Handshake/bus bundle between the Winograd tile scheduler and its input RAM,
// tile engine, output RAM and job controller.
interface winograd_tile_scheduler_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 8,
  parameter int unsigned ADDR_W = 16
);
  logic                          start;
  logic [DIM_W-1:0]              img_rows;
  logic [DIM_W-1:0]              img_cols;
  logic [0:2][0:2][DATA_W-1:0]   kernel_in;
  logic                          in_rd_en;
  logic [ADDR_W-1:0]             in_rd_addr;
  logic [DATA_W-1:0]             in_rd_data;
  logic                          tc_start;
  logic [0:2][0:2][DATA_W-1:0]   tc_kernel;
  logic [0:5][0:5][DATA_W-1:0]   tc_tile;
  logic [0:3][0:3][DATA_W-1:0]   tc_result;
  logic                          tc_done;
  logic                          out_wr_en;
  logic [ADDR_W-1:0]             out_wr_addr;
  logic [DATA_W-1:0]             out_wr_data;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    input  start, img_rows, img_cols, kernel_in, in_rd_data, tc_result, tc_done,
    output in_rd_en, in_rd_addr, tc_start, tc_kernel, tc_tile,
           out_wr_en, out_wr_addr, out_wr_data, busy, done, err
  );

  modport slave (
    output start, img_rows, img_cols, kernel_in, in_rd_data, tc_result, tc_done,
    input  in_rd_en, in_rd_addr, tc_start, tc_kernel, tc_tile,
           out_wr_en, out_wr_addr, out_wr_data, busy, done, err
  );
endinterface

// File: rtl/winograd_tile_scheduler.sv
// Winograd F(4x4,3x3) tile scheduler: gathers zero-padded 6x6 tiles (stride 4), fires the
// tile engine, scatters 4x4 results. Optional engine watchdog: WINOGRAD_SCHED_TIMEOUT_EN.
module winograd_tile_scheduler #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAX_DIM = 255
`ifdef WINOGRAD_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input logic                        clk,
  input logic                        rst_n,
  winograd_tile_scheduler_if.master  bus
);
  localparam int unsigned CW = DIM_W + 1;  // image coordinate incl. tile overhang

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_STORE, S_DONE} state_t;

  state_t                      state;
  logic [DIM_W-1:0]            rows_q, cols_q, orows_c, ocols_c;
  logic [CW-1:0]               org_r, org_c, nxt_org_r_c, nxt_org_c_c;
  logic [CW-1:0]               iss_r_c, iss_c_c, st_r_c, st_c_c;
  logic [2:0]                  er, ec, ner_c, nec_c, cap_r, cap_c;
  logic [5:0]                  cnt;
  logic [3:0]                  scnt, snx_c;
  logic                        cap_v, cap_rd, tc_done_q;
  logic                        bad_dims_c, last_col_c, last_tile_c, iss_hit_c, st_hit_c;
  logic [ADDR_W-1:0]           iss_addr_c, st_addr_c;
  logic [DATA_W-1:0]           st_data_c;
  logic [0:3][0:3][DATA_W-1:0] res_q;
`ifdef WINOGRAD_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]               wcnt;
`endif

  // Next read element, next tile origin and next store element
  always_comb begin
    orows_c     = rows_q - DIM_W'(2);
    ocols_c     = cols_q - DIM_W'(2);
    bad_dims_c  = (bus.img_rows < DIM_W'(3)) || (bus.img_cols < DIM_W'(3)) ||
                  (32'(bus.img_rows) > MAX_DIM) || (32'(bus.img_cols) > MAX_DIM);
    last_col_c  = (org_c + CW'(4)) >= CW'(ocols_c);
    last_tile_c = last_col_c && ((org_r + CW'(4)) >= CW'(orows_c));
    nxt_org_c_c = last_col_c ? '0 : org_c + CW'(4);
    nxt_org_r_c = last_col_c ? org_r + CW'(4) : org_r;
    nec_c       = (ec == 3'd5) ? 3'd0 : ec + 3'd1;
    ner_c       = (ec == 3'd5) ? er + 3'd1 : er;
    iss_r_c     = org_r + CW'(ner_c);
    iss_c_c     = org_c + CW'(nec_c);
    if (state == S_STORE) begin
      iss_r_c = nxt_org_r_c;
      iss_c_c = nxt_org_c_c;
    end
    iss_hit_c   = (iss_r_c < CW'(rows_q)) && (iss_c_c < CW'(cols_q));
    iss_addr_c  = ADDR_W'(iss_r_c) * ADDR_W'(cols_q) + ADDR_W'(iss_c_c);
    snx_c       = (state == S_WAIT) ? 4'd0 : scnt + 4'd1;
    st_r_c      = org_r + CW'(snx_c[3:2]);
    st_c_c      = org_c + CW'(snx_c[1:0]);
    st_hit_c    = (st_r_c < CW'(orows_c)) && (st_c_c < CW'(ocols_c));
    st_addr_c   = ADDR_W'(st_r_c) * ADDR_W'(ocols_c) + ADDR_W'(st_c_c);
    st_data_c   = (state == S_WAIT) ? bus.tc_result[0][0] : res_q[snx_c[3:2]][snx_c[1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      rows_q          <= '0;
      cols_q          <= '0;
      org_r           <= '0;
      org_c           <= '0;
      er              <= '0;
      ec              <= '0;
      cnt             <= '0;
      cap_v           <= 1'b0;
      cap_rd          <= 1'b0;
      cap_r           <= '0;
      cap_c           <= '0;
      scnt            <= '0;
      tc_done_q       <= 1'b0;
      res_q           <= '0;
      bus.in_rd_en    <= 1'b0;
      bus.in_rd_addr  <= '0;
      bus.tc_start    <= 1'b0;
      bus.tc_kernel   <= '0;
      bus.tc_tile     <= '0;
      bus.out_wr_en   <= 1'b0;
      bus.out_wr_addr <= '0;
      bus.out_wr_data <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
`ifdef WINOGRAD_SCHED_TIMEOUT_EN
      wcnt            <= '0;
`endif
    end else begin
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.tc_start <= 1'b0;
      // Plain level history: a tc_done still high from the last tile never looks like an edge
      tc_done_q    <= bus.tc_done;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bad_dims_c) begin
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else begin
              rows_q         <= bus.img_rows;
              cols_q         <= bus.img_cols;
              bus.tc_kernel  <= bus.kernel_in;
              bus.busy       <= 1'b1;
              org_r          <= '0;
              org_c          <= '0;
              er             <= '0;
              ec             <= '0;
              cnt            <= '0;
              cap_v          <= 1'b0;
              bus.in_rd_en   <= 1'b1;
              bus.in_rd_addr <= '0;
              state          <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Read data lags the strobe by one cycle; unread slots are zero padding
          if (cap_v) bus.tc_tile[cap_r][cap_c] <= cap_rd ? bus.in_rd_data : '0;
          cap_v          <= (cnt < 6'd36);
          cap_r          <= er;
          cap_c          <= ec;
          cap_rd         <= bus.in_rd_en;
          cnt            <= cnt + 6'd1;
          er             <= ner_c;
          ec             <= nec_c;
          bus.in_rd_en   <= (cnt < 6'd35) && iss_hit_c;
          bus.in_rd_addr <= iss_addr_c;
          if (cnt == 6'd36) begin
            bus.tc_start <= 1'b1;
            state        <= S_FIRE;
          end
        end
        S_FIRE: begin
`ifdef WINOGRAD_SCHED_TIMEOUT_EN
          wcnt  <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tc_done && !tc_done_q) begin
            res_q           <= bus.tc_result;
            scnt            <= '0;
            bus.out_wr_en   <= st_hit_c;
            bus.out_wr_addr <= st_addr_c;
            bus.out_wr_data <= st_data_c;
            state           <= S_STORE;
          end
`ifdef WINOGRAD_SCHED_TIMEOUT_EN
          else if (wcnt == TW'(TIMEOUT_CYC - 1)) begin
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_DONE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
`endif
        end
        S_STORE: begin
          if (scnt == 4'd15) begin
            bus.out_wr_en <= 1'b0;
            if (last_tile_c) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= S_DONE;
            end else begin
              org_r          <= nxt_org_r_c;
              org_c          <= nxt_org_c_c;
              er             <= '0;
              ec             <= '0;
              cnt            <= '0;
              cap_v          <= 1'b0;
              bus.in_rd_en   <= iss_hit_c;
              bus.in_rd_addr <= iss_addr_c;
              state          <= S_LOAD;
            end
          end else begin
            scnt            <= snx_c;
            bus.out_wr_en   <= st_hit_c;
            bus.out_wr_addr <= st_addr_c;
            bus.out_wr_data <= st_data_c;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Directed bench for winograd_tile_scheduler: RAM and tile-engine models, a negedge
// monitor, and hand-computed expectations for each job.
module tb_winograd_tile_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  winograd_tile_scheduler_if bus ();
  winograd_tile_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] img_mem [0:255];
  logic [31:0] out_mem [0:255];

  // engine: mode 0 one-cycle done pulse, 1 done left high between tiles, 2 never done
  int eng_mode = 0;
  int eng_lat  = 8;
  int eng_cnt  = 0;

  // monitor state (written only by the monitor)
  int cyc = 0, rd_cnt = 0, rd_max = 0, wr_cnt = 0, wr_max = 0, tcs_cnt = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, last_wr_cyc = 0;
  int clr_gen = 0, clr_seen = 0;
  logic done_err = 1'b0, first_wr = 1'b0;
  int gaps [$];

  function automatic logic [0:3][0:3][31:0] conv(input logic [0:5][0:5][31:0] t,
                                                 input logic [0:2][0:2][31:0] k);
    logic [0:3][0:3][31:0] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        r[i][j] = '0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            r[i][j] = r[i][j] + t[i+a][j+b] * k[a][b];
      end
    return r;
  endfunction

  always @(posedge clk) begin
    bus.in_rd_data <= bus.in_rd_en ? img_mem[bus.in_rd_addr[7:0]] : 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (bus.tc_start) eng_cnt <= eng_lat;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    if (eng_mode == 2) bus.tc_done <= 1'b0;
    else if (eng_cnt == 1) begin
      bus.tc_done   <= 1'b1;
      bus.tc_result <= conv(bus.tc_tile, bus.tc_kernel);
    end else if (eng_cnt == 2 || eng_mode == 0) bus.tc_done <= 1'b0;
  end

  always @(negedge clk) begin
    if (clr_seen != clr_gen) begin
      clr_seen = clr_gen;
      rd_cnt = 0; rd_max = 0; wr_cnt = 0; wr_max = 0; tcs_cnt = 0; done_cnt = 0;
      gaps.delete();
      for (int i = 0; i < 256; i++) out_mem[i] = 32'hFFFFFFFF;
    end
    cyc++;
    if (bus.in_rd_en) begin
      rd_cnt++;
      if (int'(bus.in_rd_addr) > rd_max) rd_max = int'(bus.in_rd_addr);
    end
    if (bus.tc_start) begin
      tcs_cnt++; start_cyc = cyc; first_wr = 1'b1;
    end
    if (bus.out_wr_en) begin
      wr_cnt++;
      out_mem[bus.out_wr_addr[7:0]] = bus.out_wr_data;
      if (int'(bus.out_wr_addr) > wr_max) wr_max = int'(bus.out_wr_addr);
      last_wr_cyc = cyc;
      if (first_wr) begin gaps.push_back(cyc - start_cyc); first_wr = 1'b0; end
    end
    if (bus.done) begin done_cnt++; done_cyc = cyc; done_err = bus.err; end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    clr_gen++;
    step();
  endtask

  // pattern 0: img[r][c] = 10r+c, pattern 1: all ones
  task automatic set_img(input int rows, input int cols, input int pat);
    for (int a = 0; a < 256; a++) img_mem[a] = 32'hBAD0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        img_mem[r*cols+c] = (pat == 0) ? 32'(10*r + c) : 32'd1;
  endtask

  task automatic set_kernel(input bit ones);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        bus.kernel_in[a][b] = (ones || (a == 1 && b == 1)) ? 32'd1 : 32'd0;
  endtask

  task automatic pulse_start(input int rows, input int cols);
    bus.img_rows = 8'(rows);
    bus.img_cols = 8'(cols);
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin step(); n++; end
    chk("done_seen", done_cnt, 1);
  endtask

  initial begin
    int n_ok;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.img_rows = '0;
    bus.img_cols = '0;
    bus.kernel_in = '0;
    repeat (3) step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_rd_en", int'(bus.in_rd_en), 0);
    chk("rst_wr_en", int'(bus.out_wr_en), 0);
    chk("rst_tile_kernel", int'(bus.tc_tile == '0 && bus.tc_kernel == '0), 1);
    rst_n = 1'b1;
    step();

    // 6x6 ramp, centre kernel: single tile, out = shifted image
    set_img(6, 6, 0); set_kernel(1'b0); clr();
    pulse_start(6, 6);
    chk("j1_busy", int'(bus.busy), 1);
    wait_done(2000);
    chk("j1_busy_at_done", int'(bus.busy), 0);
    chk("j1_err", int'(done_err), 0);
    chk("j1_reads", rd_cnt, 36);
    chk("j1_tc_start", tcs_cnt, 1);
    chk("j1_writes", wr_cnt, 16);
    chk("j1_tile55", int'(bus.tc_tile[5][5]), 55);
    chk("j1_kernel", int'(bus.tc_kernel[1][1]), 1);
    n_ok = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (out_mem[i*4+j] == 32'(10*(i+1) + j + 1)) n_ok++;
    chk("j1_out_vals", n_ok, 16);

    // 10x10 ones, ones kernel: 4 tiles, every output 9
    set_img(10, 10, 1); set_kernel(1'b1); clr();
    pulse_start(10, 10);
    wait_done(2000);
    chk("j2_tc_start", tcs_cnt, 4);
    chk("j2_reads", rd_cnt, 144);
    chk("j2_writes", wr_cnt, 64);
    n_ok = 0;
    for (int a = 0; a < 64; a++) if (out_mem[a] == 32'd9) n_ok++;
    chk("j2_out_vals", n_ok, 64);
    chk("j2_done_after_last_wr", done_cyc - last_wr_cyc, 1);

    // 7x7 ramp: partial edge tiles, zero padding, clipped writes
    set_img(7, 7, 0); set_kernel(1'b0); clr();
    pulse_start(7, 7);
    wait_done(2000);
    chk("j3_tc_start", tcs_cnt, 4);
    chk("j3_reads", rd_cnt, 81);
    chk("j3_rd_max", rd_max, 48);
    chk("j3_writes", wr_cnt, 25);
    chk("j3_wr_max", wr_max, 24);
    chk("j3_out0", int'(out_mem[0]), 11);
    chk("j3_out9", int'(out_mem[9]), 25);
    chk("j3_out24", int'(out_mem[24]), 55);
    chk("j3_tile22", int'(bus.tc_tile[2][2]), 66);
    chk("j3_pad03", int'(bus.tc_tile[0][3]), 0);
    chk("j3_pad55", int'(bus.tc_tile[5][5]), 0);

    // bad dimensions: immediate done+err, no activity
    clr();
    pulse_start(2, 5);
    chk("j4_done", int'(bus.done), 1);
    chk("j4_err", int'(bus.err), 1);
    step();
    chk("j4_done_pulse", int'(bus.done), 0);
    repeat (5) step();
    chk("j4_no_activity", rd_cnt + tcs_cnt + wr_cnt, 0);

    // held tc_done across tiles plus an ignored start during WAIT
    set_img(10, 10, 0); set_kernel(1'b0); eng_mode = 1; clr();
    pulse_start(10, 10);
    n_ok = 0;
    while (tcs_cnt == 0 && n_ok < 200) begin step(); n_ok++; end
    step();
    pulse_start(2, 5);
    wait_done(2000);
    chk("j5_done_cnt", done_cnt, 1);
    chk("j5_err", int'(done_err), 0);
    chk("j5_writes", wr_cnt, 64);
    n_ok = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (out_mem[i*8+j] == 32'(10*(i+1) + j + 1)) n_ok++;
    chk("j5_out_vals", n_ok, 64);
    chk("j5_gap_count", gaps.size(), 4);
    foreach (gaps[g]) chk("j5_start_to_write", gaps[g], eng_lat + 2);
    eng_mode = 0;
    repeat (3) step();

`ifdef WINOGRAD_SCHED_TIMEOUT_EN
    // engine never answers: watchdog ends the job with err
    set_img(6, 6, 0); eng_mode = 2; clr();
    pulse_start(6, 6);
    wait_done(6000);
    chk("to_err", int'(done_err), 1);
    chk("to_latency", done_cyc - start_cyc, 4097);
    chk("to_writes", wr_cnt, 0);
    eng_mode = 0;
    step();
`endif

    // reset in the middle of LOAD clears every output
    set_img(6, 6, 1); set_kernel(1'b1); clr();
    pulse_start(6, 6);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", int'(bus.in_rd_en), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_tile_kernel", int'(bus.tc_tile == '0 && bus.tc_kernel == '0), 1);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
